green_fetch: RTL and testbench
==============================

// Module: green_fetch
//
// PURPOSE
// - Instruction fetch/sequencer for the green circuit: the producer that feeds 16-bit instruction words to the green decoder and consumes its BR (branch taken) result.
// - Owns the program counter and drives a synchronous instruction memory (1-cycle read latency).
// - Handles start, stall, branch redirect with squash, and HALT.
// - Presents a NOP word whenever no valid instruction is held.
//
// PARAMETERS
// - ADDR_W   8      instruction address width; legal range 1..12 (branch target comes from ins[ADDR_W-1:0])
// - RESET_PC 0      PC loaded on reset and on start from IDLE/HALT
//
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       asynchronous, active-high reset
// - start      in   1       pulse; begins/resumes fetching from RESET_PC when in IDLE or HALT; ignored in RUN
// - stall      in   1       freeze: no fetch issued, all state held
// - imem_en    out  1       instruction memory read enable
// - imem_addr  out  ADDR_W  read address (= pc)
// - imem_data  in   16      read data, valid the cycle after imem_en; memory holds dout while imem_en=0
// - ins        out  16      instruction to decoder; ins_r when ins_valid, else NOP_WORD (16'h4000)
// - ins_valid  out  1       ins carries a real fetched instruction
// - BR         in   1       decoder branch-taken, combinational from ins this cycle
// - pc_out     out  ADDR_W  current fetch pc
// - halted     out  1       state == HALT
//
// BEHAVIOUR
// - State machine: IDLE, RUN, HALT.
//   - IDLE -> RUN on start.
//   - RUN -> HALT when ins_valid && ins[15:12]==4'hF && !stall.
//   - HALT -> RUN on start.
// - Reset values:
//   - state=IDLE, pc=RESET_PC, pend=0, ins_r=NOP_WORD, ins_valid=0.
//   - imem_en=0, halted=0, ins=16'h4000.
// - Fetch: in RUN with !stall and no redirect/halt this cycle:
//   - imem_en=1, imem_addr=pc.
//   - pc<=pc+1 (mod 2^ADDR_W, FFh wraps to 00h at default width).
//   - pend<=1.
// - Capture: when pend && !stall && no redirect/halt:
//   - ins_r<=imem_data, ins_valid<=1.
//   - If pend=0: ins_valid<=0.
// - Throughput: one instruction per cycle sustained; first ins_valid 2 cycles after start.
// - Branch: ins_valid && BR && !stall.
//   - pc<=ins[ADDR_W-1:0].
//   - imem_en=0 this cycle; pend<=0 (in-flight word squashed); ins_valid<=0.
//   - Target fetched next cycle, valid the cycle after.
//   - Penalty: 2 bubble cycles.
// - HALT entry: same squash as branch; pc holds; imem_en=0 while halted.
//   - start from HALT reloads pc=RESET_PC (registered), first fetch next cycle.
// - Stall: highest priority after rst.
//   - imem_en=0; pc, pend, ins_r, ins_valid, state all held.
//   - A pending response is captured after stall releases (memory holds dout).
//   - BR/HALT are evaluated only on a non-stalled cycle.
// - Priority per cycle: rst > stall > HALT opcode > BR > normal fetch/capture.
// - Opcodes 4'h4..4'hE: passed through as-is; no effect on this block.
// - ins_valid=0 or IDLE/HALT: ins=NOP_WORD, so decoder WE=0 and BR=0.
// - rst mid-operation: all state returns to reset values immediately (async); pending fetch discarded.
//
// STRUCTURE
// - green_pkg:
//   - OPC_LD=4'h0, OPC_ST=4'h1, OPC_INC=4'h2, OPC_BR=4'h3, OPC_NOP=4'h4, OPC_HALT=4'hF
//   - NOP_WORD=16'h4000
//   - state encoding
// - One sub-module: green_pc.
//   - ADDR_W counter with load (target/RESET_PC), increment, hold.
// - FSM, pend/ins registers and squash logic stay in green_fetch.
//
// TESTING
// - Reset, then start with mem[0..3]=0000,2000,2800,1000:
//   - ins_valid rises 2 cycles after start.
//   - ins sequence 0000,2000,2800,1000 on consecutive cycles.
//   - pc_out 1,2,3,4...
// - Branch: mem[2]=16'h3010, BR=1 when seen:
//   - word at addr 3 never appears.
//   - 2 cycles of ins=16'h4000/ins_valid=0.
//   - then ins=mem[16'h10].
// - Stall 3 cycles while pend=1:
//   - imem_en=0 throughout.
//   - ins/ins_valid/pc_out unchanged.
//   - after release the pending word appears next; no word lost or duplicated.
// - HALT: mem[5]=16'hF000:
//   - halted=1 the cycle after F000 is valid; imem_en stays 0.
//   - start resumes at RESET_PC.
// - Wrap at ADDR_W=8: pc=FFh fetches FFh then 00h.
// - Async rst asserted mid-stream:
//   - ins_valid=0, ins=4000, pc_out=RESET_PC without a clock edge; state=IDLE.

Source files
------------

// File: rtl/green_pkg.sv
// Shared opcodes, idle instruction word and sequencer state encoding for the green circuit.
package green_pkg;

    localparam logic [3:0] OPC_LD   = 4'h0;
    localparam logic [3:0] OPC_ST   = 4'h1;
    localparam logic [3:0] OPC_INC  = 4'h2;
    localparam logic [3:0] OPC_BR   = 4'h3;
    localparam logic [3:0] OPC_NOP  = 4'h4;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [15:0] NOP_WORD = {OPC_NOP, 12'h000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == OPC_HALT;
    endfunction

endpackage

// File: rtl/green_pc.sv
// Program counter: load (branch target or restart address) beats increment; otherwise holds.
module green_pc
    import green_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/green_fetch.sv
// Instruction fetch/sequencer: drives the 1-cycle instruction memory, feeds the decoder,
// and handles start, stall, branch squash and HALT.
//
// state   | meaning
// IDLE    | out of reset, waiting for start
// RUN     | fetching one word per cycle
// HALT    | HALT opcode retired, waiting for start to restart at RESET_PC
module green_fetch
    import green_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       ins,
    output logic              ins_valid,
    input  logic              BR,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    state_e            state_q;
    logic              pend_q;
    logic [15:0]       ins_r_q;
    logic              ins_valid_q;
    logic              halted_q;

    logic              running;
    logic              halt_hit;
    logic              br_hit;
    logic              fetch;
    logic              start_go;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] pc;

    always_comb begin
        running     = (state_q == ST_RUN);
        halt_hit    = running && !stall && ins_valid_q && is_halt(ins_r_q);
        br_hit      = running && !stall && ins_valid_q && BR && !halt_hit;
        fetch       = running && !stall && !halt_hit && !br_hit;
        start_go    = start && !stall && (state_q != ST_RUN);
        pc_load     = br_hit || start_go;
        pc_load_val = br_hit ? ins_r_q[ADDR_W-1:0] : RESET_PC;
    end

    green_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (fetch),
        .pc_o       (pc)
    );

    // Stall freezes everything; the memory keeps its dout so a pending word survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            ins_r_q     <= NOP_WORD;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        state_q     <= ST_HALT;
                        halted_q    <= 1'b1;
                        pend_q      <= 1'b0;
                        ins_valid_q <= 1'b0;
                    end else if (br_hit) begin
                        pend_q      <= 1'b0;
                        ins_valid_q <= 1'b0;
                    end else begin
                        pend_q      <= 1'b1;
                        ins_valid_q <= pend_q;
                        if (pend_q) begin
                            ins_r_q <= imem_data;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_en   = fetch;
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign ins       = ins_valid_q ? ins_r_q : NOP_WORD;
    assign ins_valid = ins_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_green_fetch.sv
// Scoreboard bench for green_fetch: a behavioural memory, a decoder BR model and an in-order checker.
module tb_green_fetch;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data = 16'h0000;
    logic [15:0]       ins;
    logic              ins_valid;
    logic              BR;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    logic        mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    green_fetch #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ins       (ins),
        .ins_valid (ins_valid),
        .BR        (BR),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    // Decoder model: branch taken whenever a valid BR opcode is presented.
    assign BR = ins_valid && (ins[15:12] == 4'h3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A word is consumed by the decoder on every non-stalled cycle it is valid.
    always @(negedge clk) begin
        if (mon_en && !rst && ins_valid && !stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h expected none", ins);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (ins !== e) begin
                    n_err++;
                    $display("FAIL sb_word: got %h expected %h", ins, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0BAD;
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input logic [15:0] w, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (ins_valid && ins === w) found = 1'b1;
            else tick();
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    task automatic push_words(input logic [15:0] w [], input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    endtask

    initial begin
        logic [15:0] prog_a [] = '{16'h0000, 16'h2000, 16'h2800, 16'h1000, 16'h4123, 16'hF000};
        logic [15:0] prog_b [] = '{16'h0000, 16'h2000, 16'h3010, 16'h2AAA, 16'hF000};
        logic [15:0] saved_ins;
        logic [ADDR_W-1:0] saved_pc;
        int n;

        #2;
        chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins", {16'd0, ins}, 32'h4000);
        chk("rst_pc", {24'd0, pc_out}, 32'h00);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Straight-line run, HALT, then restart from RESET_PC.
        do_reset();
        mem[0] = 16'h0000; mem[1] = 16'h2000; mem[2] = 16'h2800;
        mem[3] = 16'h1000; mem[4] = 16'h4123; mem[5] = 16'hF000; mem[6] = 16'h2222;
        mon_en = 1'b1;
        push_words(prog_a, 6);
        pulse_start();
        chk("a_first_en", {31'd0, imem_en}, 32'd1);
        chk("a_first_addr", {24'd0, imem_addr}, 32'h00);
        n = 0;
        while (!ins_valid && n < 10) begin
            tick();
            n++;
        end
        chk("a_first_valid_latency", n, 32'd2);
        chk("a_pc_at_first", {24'd0, pc_out}, 32'h02);
        wait_word(16'hF000, "a_see_halt");
        tick();
        chk("a_halted", {31'd0, halted}, 32'd1);
        chk("a_halt_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("a_halt_ins", {16'd0, ins}, 32'h4000);
        chk("a_halt_en", {31'd0, imem_en}, 32'd0);
        chk("a_halt_pc", {24'd0, pc_out}, 32'h07);
        tick();
        tick();
        chk("a_halt_en_held", {31'd0, imem_en}, 32'd0);
        chk("a_halt_pc_held", {24'd0, pc_out}, 32'h07);
        push_words(prog_a, 6);
        pulse_start();
        chk("a_resume_halted", {31'd0, halted}, 32'd0);
        chk("a_resume_pc", {24'd0, pc_out}, 32'h00);
        chk("a_resume_en", {31'd0, imem_en}, 32'd1);
        wait_word(16'hF000, "a_see_halt2");
        tick();
        chk("a_halted2", {31'd0, halted}, 32'd1);
        chk("a_sb_drained", exp_q.size(), 32'd0);

        // Branch with squash of the word at address 3.
        do_reset();
        mem[0] = 16'h0000; mem[1] = 16'h2000; mem[2] = 16'h3010; mem[3] = 16'h1111;
        mem[8'h10] = 16'h2AAA; mem[8'h11] = 16'hF000;
        push_words(prog_b, 5);
        pulse_start();
        wait_word(16'h3010, "b_see_br");
        chk("b_br_en", {31'd0, imem_en}, 32'd0);
        tick();
        chk("b_bubble1_valid", {31'd0, ins_valid}, 32'd0);
        chk("b_bubble1_ins", {16'd0, ins}, 32'h4000);
        chk("b_target_fetch", {24'd0, imem_addr}, 32'h10);
        tick();
        chk("b_bubble2_valid", {31'd0, ins_valid}, 32'd0);
        chk("b_bubble2_ins", {16'd0, ins}, 32'h4000);
        tick();
        chk("b_target_valid", {31'd0, ins_valid}, 32'd1);
        chk("b_target_ins", {16'd0, ins}, 32'h2AAA);
        wait_word(16'hF000, "b_see_halt");
        tick();
        chk("b_halted", {31'd0, halted}, 32'd1);
        chk("b_sb_drained", exp_q.size(), 32'd0);

        // Three-cycle stall with a fetch in flight.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 16'h2000 + 16'(i);
            exp_q.push_back(16'h2000 + 16'(i));
        end
        mem[8] = 16'hF000;
        exp_q.push_back(16'hF000);
        pulse_start();
        wait_word(16'h2000, "c_first");
        saved_ins = ins;
        saved_pc  = pc_out;
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("c_stall_en", {31'd0, imem_en}, 32'd0);
            chk("c_stall_ins", {16'd0, ins}, {16'd0, saved_ins});
            chk("c_stall_valid", {31'd0, ins_valid}, 32'd1);
            chk("c_stall_pc", {24'd0, pc_out}, {24'd0, saved_pc});
            tick();
        end
        stall = 1'b0;
        tick();
        chk("c_after_release", {16'd0, ins}, 32'h2001);
        wait_word(16'hF000, "c_see_halt");
        tick();
        chk("c_halted", {31'd0, halted}, 32'd1);
        chk("c_sb_drained", exp_q.size(), 32'd0);

        // PC wrap FFh -> 00h, then asynchronous reset mid-stream.
        mon_en = 1'b0;
        do_reset();
        mem[0] = 16'h2001; mem[1] = 16'h30FF; mem[2] = 16'h1234; mem[8'hFF] = 16'h2FF0;
        pulse_start();
        n = 0;
        while (!(imem_en && imem_addr == 8'hFF) && n < 20) begin
            tick();
            n++;
        end
        chk("d_fetch_ff", {31'd0, imem_en && imem_addr == 8'hFF}, 32'd1);
        tick();
        chk("d_wrap_en", {31'd0, imem_en}, 32'd1);
        chk("d_wrap_addr", {24'd0, imem_addr}, 32'h00);
        tick();
        chk("d_ins_ff", {16'd0, ins}, 32'h2FF0);
        tick();
        chk("d_ins_00", {16'd0, ins}, 32'h2001);
        chk("d_pre_rst_valid", {31'd0, ins_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("d_arst_valid", {31'd0, ins_valid}, 32'd0);
        chk("d_arst_ins", {16'd0, ins}, 32'h4000);
        chk("d_arst_pc", {24'd0, pc_out}, 32'h00);
        chk("d_arst_en", {31'd0, imem_en}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("d_idle_en", {31'd0, imem_en}, 32'd0);
        chk("d_idle_valid", {31'd0, ins_valid}, 32'd0);
        chk("d_idle_halted", {31'd0, halted}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
